// File: rtl/arc4_param.sv
// ARC4 decryption core: S-box init, key schedule, optional keystream drop and
// length-prefixed message decryption in one FSM, with a printable-text flag.
module arc4_param #(
  parameter int KEY_BYTES   = 3,
  parameter int DROP        = 0,
  parameter bit CHECK_PRINT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren,
  output logic                   pt_valid
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA, DROPS, LEN1, LEN2, MSG1, MSG2, MSG3, DONE
  } state_t;

  localparam logic [4:0] KEY_LAST  = 5'(KEY_BYTES - 1);
  localparam logic [9:0] DROP_LAST = (DROP > 0) ? 10'(DROP - 1) : 10'd0;

  state_t state_reg, state_next;

  logic [7:0]             s_mem [256];
  logic [KEY_BYTES*8-1:0] key_reg;
  logic [7:0]             i_reg, j_reg, k_reg, len_reg;
  logic [9:0]             cnt_reg;
  logic [4:0]             kidx_reg;

  logic [7:0] i_inc, s_i, s_i_inc, kb;
  logic [7:0] j_ksa, j_drop, j_msg, pad_idx, pad, pt_byte;

  // Key byte 0 is the most significant byte of the key word.
  always_comb begin
    kb = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_reg == 5'(b)) kb = key_reg[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

  assign i_inc   = i_reg + 8'd1;
  assign s_i     = s_mem[i_reg];
  assign s_i_inc = s_mem[i_inc];
  assign j_ksa   = j_reg + s_i + kb;
  assign j_drop  = j_reg + s_i_inc;
  assign j_msg   = j_reg + s_i;
  assign pad_idx = s_mem[i_reg] + s_mem[j_reg];
  assign pad     = s_mem[pad_idx];
  assign pt_byte = pad ^ ct_rddata;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rdy        = 1'b0;
    pt_wren    = 1'b0;
    pt_addr    = 8'd0;
    pt_wrdata  = 8'd0;
    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_next = INIT;
      end
      INIT:  if (cnt_reg == 10'd255) state_next = KSA;
      KSA:   if (i_reg == 8'hFF) state_next = (DROP > 0) ? DROPS : LEN1;
      DROPS: if (cnt_reg == DROP_LAST) state_next = LEN1;
      LEN1:  state_next = LEN2;
      LEN2: begin
        pt_wren    = 1'b1;
        pt_wrdata  = ct_rddata;
        state_next = (ct_rddata == 8'd0) ? DONE : MSG1;
      end
      MSG1: state_next = MSG2;
      MSG2: state_next = MSG3;
      MSG3: begin
        pt_wren    = 1'b1;
        pt_addr    = k_reg;
        pt_wrdata  = pt_byte;
        state_next = (k_reg == len_reg) ? DONE : MSG1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg  <= '0;
      i_reg    <= 8'd0;
      j_reg    <= 8'd0;
      k_reg    <= 8'd0;
      len_reg  <= 8'd0;
      cnt_reg  <= 10'd0;
      kidx_reg <= 5'd0;
      ct_addr  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (en) begin
          key_reg <= key;
          cnt_reg <= 10'd0;
          i_reg   <= 8'd0;
          j_reg   <= 8'd0;
          ct_addr <= 8'd0;
        end
        INIT: begin
          s_mem[cnt_reg[7:0]] <= cnt_reg[7:0];
          cnt_reg <= cnt_reg + 10'd1;
          if (cnt_reg == 10'd255) begin
            cnt_reg  <= 10'd0;
            i_reg    <= 8'd0;
            j_reg    <= 8'd0;
            kidx_reg <= 5'd0;
          end
        end
        KSA: begin
          s_mem[i_reg] <= s_mem[j_ksa];
          s_mem[j_ksa] <= s_i;
          i_reg        <= i_inc;
          j_reg        <= j_ksa;
          kidx_reg     <= (kidx_reg == KEY_LAST) ? 5'd0 : kidx_reg + 5'd1;
          // Keystream generation starts from i = j = 0 (i wraps on its own).
          if (i_reg == 8'hFF) j_reg <= 8'd0;
        end
        DROPS: begin
          s_mem[i_inc]  <= s_mem[j_drop];
          s_mem[j_drop] <= s_i_inc;
          i_reg         <= i_inc;
          j_reg         <= j_drop;
          cnt_reg       <= cnt_reg + 10'd1;
        end
        LEN2: begin
          len_reg <= ct_rddata;
          k_reg   <= 8'd1;
          ct_addr <= 8'd1;
        end
        MSG1: i_reg <= i_inc;
        MSG2: begin
          s_mem[i_reg] <= s_mem[j_msg];
          s_mem[j_msg] <= s_i;
          j_reg        <= j_msg;
        end
        MSG3: if (k_reg != len_reg) begin
          k_reg   <= k_reg + 8'd1;
          ct_addr <= k_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (CHECK_PRINT) begin : g_check
      logic valid_reg;
      always_ff @(posedge clk) begin
        if (rst)
          valid_reg <= 1'b1;
        else if (state_reg == IDLE && en)
          valid_reg <= 1'b1;
        else if (state_reg == MSG3 && (pt_byte < 8'h20 || pt_byte > 8'h7E))
          valid_reg <= 1'b0;
      end
      assign pt_valid = valid_reg;
    end else begin : g_nocheck
      assign pt_valid = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_arc4_param.sv
// Directed bench for arc4_param: three instances (key length 3, key length 4,
// drop 1) with behavioural ciphertext/plaintext RAMs.
module tb_arc4_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en [3];
  logic        rdy [3];
  logic [7:0]  ct_addr [3];
  logic [7:0]  ct_rddata [3];
  logic [7:0]  pt_addr [3];
  logic [7:0]  pt_wrdata [3];
  logic        pt_wren [3];
  logic        pt_valid [3];
  logic [23:0] key_a = 24'h4B6579;
  logic [31:0] key_w = 32'h57696B69;
  logic [23:0] key_d = 24'h4B6579;

  logic [7:0] ct_mem [3][256];
  logic [7:0] pt_mem [3][256];
  int         stamp [3][256];
  int         wr_count [3];
  int         run_id [3];

  logic [7:0] ct_q [$];
  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  arc4_param #(.KEY_BYTES(3), .DROP(0), .CHECK_PRINT(1)) u_key (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key_a),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]), .pt_valid(pt_valid[0]));

  arc4_param #(.KEY_BYTES(4), .DROP(0), .CHECK_PRINT(1)) u_wiki (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key_w),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]), .pt_valid(pt_valid[1]));

  arc4_param #(.KEY_BYTES(3), .DROP(1), .CHECK_PRINT(1)) u_drop (
    .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .key(key_d),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rddata[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]), .pt_valid(pt_valid[2]));

  // Synchronous-read RAM models; every plaintext write is stamped with the run id.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      ct_rddata[n] <= ct_mem[n][ct_addr[n]];
      if (pt_wren[n]) begin
        pt_mem[n][pt_addr[n]] <= pt_wrdata[n];
        stamp[n][pt_addr[n]]  <= run_id[n];
        wr_count[n]           <= wr_count[n] + 1;
      end
    end
  end

  task automatic load_ct(input int n);
    for (int b = 0; b < ct_q.size(); b++) ct_mem[n][b] = ct_q[b];
  endtask

  task automatic start(input int n);
    run_id[n] = run_id[n] + 1;
    @(negedge clk);
    en[n] = 1'b1;
    @(posedge clk);
    #1;
    en[n] = 1'b0;
  endtask

  task automatic wait_rdy(input int n, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!rdy[n] && cycles < budget);
    $display("[TB] inst %0d run %0d done after %0d cycles", n, run_id[n], cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      tests++; if (rdy[n] !== 1'b1) begin fails++; $display("FAIL reset_rdy[%0d]: got %b expected 1", n, rdy[n]); end
      tests++; if (pt_wren[n] !== 1'b0) begin fails++; $display("FAIL reset_wren[%0d]: got %b expected 0", n, pt_wren[n]); end
      tests++; if (pt_valid[n] !== 1'b1) begin fails++; $display("FAIL reset_valid[%0d]: got %b expected 1", n, pt_valid[n]); end
      tests++; if (ct_addr[n] !== 8'h00) begin fails++; $display("FAIL reset_ct_addr[%0d]: got %02h expected 00", n, ct_addr[n]); end
      tests++; if (pt_addr[n] !== 8'h00) begin fails++; $display("FAIL reset_pt_addr[%0d]: got %02h expected 00", n, pt_addr[n]); end
      tests++; if (pt_wrdata[n] !== 8'h00) begin fails++; $display("FAIL reset_wrdata[%0d]: got %02h expected 00", n, pt_wrdata[n]); end
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_key_plaintext(input string tag);
    int cyc, wc0;
    ct_q  = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    exp_q = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    load_ct(0);
    wc0 = wr_count[0];
    start(0);
    wait_rdy(0, 3000, cyc);
    tests++; if (cyc !== 542) begin fails++; $display("FAIL %s_latency: got %0d expected 542", tag, cyc); end
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if (stamp[0][b] !== run_id[0] || pt_mem[0][b] !== exp_q[b]) begin
        fails++; $display("FAIL %s_pt[%0d]: got %02h expected %02h", tag, b, pt_mem[0][b], exp_q[b]);
      end
    end
    tests++; if (pt_valid[0] !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b expected 1", tag, pt_valid[0]); end
    tests++; if (wr_count[0] - wc0 !== 10) begin fails++; $display("FAIL %s_writes: got %0d expected 10", tag, wr_count[0] - wc0); end
  endtask

  task automatic test_wiki();
    int cyc;
    ct_q  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    exp_q = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    load_ct(1);
    start(1);
    wait_rdy(1, 3000, cyc);
    tests++; if (cyc !== 530) begin fails++; $display("FAIL wiki_latency: got %0d expected 530", cyc); end
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if (stamp[1][b] !== run_id[1] || pt_mem[1][b] !== exp_q[b]) begin
        fails++; $display("FAIL wiki_pt[%0d]: got %02h expected %02h", b, pt_mem[1][b], exp_q[b]);
      end
    end
    tests++; if (pt_valid[1] !== 1'b1) begin fails++; $display("FAIL wiki_valid: got %b expected 1", pt_valid[1]); end
  endtask

  task automatic test_drop();
    int cyc;
    ct_q  = '{8'h08, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    exp_q = '{8'h08, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    load_ct(2);
    start(2);
    wait_rdy(2, 3000, cyc);
    tests++; if (cyc !== 540) begin fails++; $display("FAIL drop_latency: got %0d expected 540", cyc); end
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if (stamp[2][b] !== run_id[2] || pt_mem[2][b] !== exp_q[b]) begin
        fails++; $display("FAIL drop_pt[%0d]: got %02h expected %02h", b, pt_mem[2][b], exp_q[b]);
      end
    end
    tests++; if (pt_valid[2] !== 1'b1) begin fails++; $display("FAIL drop_valid: got %b expected 1", pt_valid[2]); end
  endtask

  task automatic test_nonprint();
    int cyc;
    ct_q  = '{8'h09, 8'hEC, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    exp_q = '{8'h09, 8'h07, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    load_ct(0);
    start(0);
    wait_rdy(0, 3000, cyc);
    tests++; if (cyc !== 542) begin fails++; $display("FAIL nonprint_latency: got %0d expected 542", cyc); end
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if (stamp[0][b] !== run_id[0] || pt_mem[0][b] !== exp_q[b]) begin
        fails++; $display("FAIL nonprint_pt[%0d]: got %02h expected %02h", b, pt_mem[0][b], exp_q[b]);
      end
    end
    tests++; if (pt_valid[0] !== 1'b0) begin fails++; $display("FAIL nonprint_valid: got %b expected 0", pt_valid[0]); end
    test_key_plaintext("recover");
  endtask

  task automatic test_zero_len();
    int cyc, wc0;
    ct_q = '{8'h00, 8'h41};
    load_ct(0);
    pt_mem[0][0] = 8'hAA;
    wc0 = wr_count[0];
    start(0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk);
    #1;
    en[0] = 1'b0;
    wait_rdy(0, 3000, cyc);
    cyc = cyc + 101;
    tests++; if (cyc !== 515) begin fails++; $display("FAIL zero_latency: got %0d expected 515", cyc); end
    tests++; if (stamp[0][0] !== run_id[0] || pt_mem[0][0] !== 8'h00) begin fails++; $display("FAIL zero_pt0: got %02h expected 00", pt_mem[0][0]); end
    tests++; if (stamp[0][1] === run_id[0]) begin fails++; $display("FAIL zero_pt1_written: got write expected none"); end
    tests++; if (pt_valid[0] !== 1'b1) begin fails++; $display("FAIL zero_valid: got %b expected 1", pt_valid[0]); end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (wr_count[0] - wc0 !== 1) begin fails++; $display("FAIL zero_writes: got %0d expected 1", wr_count[0] - wc0); end
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL zero_idle_rdy: got %b expected 1", rdy[0]); end
  endtask

  task automatic test_reset_mid_run();
    int wc0;
    ct_q = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_ct(0);
    wc0 = wr_count[0];
    start(0);
    repeat (524) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL midrst_rdy: got %b expected 1", rdy[0]); end
    tests++; if (pt_wren[0] !== 1'b0) begin fails++; $display("FAIL midrst_wren: got %b expected 0", pt_wren[0]); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (wr_count[0] - wc0 !== 4) begin fails++; $display("FAIL midrst_writes: got %0d expected 4", wr_count[0] - wc0); end
    $display("[TB] inst 0 run %0d abandoned by reset", run_id[0]);
    test_key_plaintext("after_rst");
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      en[n] = 1'b0;
      run_id[n] = 0;
      wr_count[n] = 0;
      for (int a = 0; a < 256; a++) begin
        ct_mem[n][a] = 8'h00;
        stamp[n][a] = 0;
      end
    end
    test_reset();
    test_key_plaintext("key");
    test_wiki();
    test_drop();
    test_nonprint();
    test_zero_len();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arc4_param.md
Name: arc4_param

Overview:
- Parametrised ARC4 (RC4) decryption core; next generation of the task5 arc4 block.
- Merges init, KSA and PRGA into one FSM with an internal 256-byte S-box held in registers.
- Adds configurable key length, RC4-drop[N] keystream discard, and a printable-plaintext flag for the key-search stage.
- Reads a length-prefixed ciphertext from ct_mem and writes a length-prefixed plaintext to pt_mem. Both are 1-cycle synchronous-read RAMs.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32). Key byte 0 = key[KEY_BYTES*8-1 -: 8] (big-endian).
- DROP, 0, keystream bytes generated and discarded before the first message byte (0..1023).
- CHECK_PRINT, 1, 1 = compute pt_valid; 0 = pt_valid tied to 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request, sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  KEY_BYTES*8  decryption key, latched when en is accepted.
- ct_addr  out  8  ciphertext RAM address.
- ct_rddata  in  8  ciphertext RAM data, valid 1 cycle after ct_addr.
- pt_addr  out  8  plaintext RAM address.
- pt_wrdata  out  8  plaintext write data.
- pt_wren  out  1  plaintext write enable, 1-cycle pulses.
- pt_valid  out  1  1 = every decrypted byte of the last run is in 0x20..0x7E. Held until the next start.

Behaviour:
- Reset values:
  - rdy=1, pt_wren=0, pt_valid=1.
  - ct_addr=0, pt_addr=0, pt_wrdata=0.
  - FSM in IDLE; i, j and all counters 0.
  - S contents don't-care.
- Reset asserted in any state: next cycle is IDLE with the reset values above, no further pt writes, and the run is abandoned.
- Handshake:
  - en=1 with rdy=1 at edge T: key is latched, rdy=0 from T+1, pt_valid is set to 1.
  - en while rdy=0 is ignored.
  - en held high after completion starts a new run immediately.
- States:
  - IDLE → INIT on accept.
  - INIT: 256 cycles, S[k]=k for k=0..255.
  - KSA: 256 cycles, one index per cycle: j = j + S[i] + keybyte[i mod KEY_BYTES] (mod 256), then swap S[i],S[j] in the same cycle. i and j are cleared at KSA entry.
  - DROP: DROP cycles, each running one PRGA step (i=i+1, j=j+S[i], swap) with the output discarded. Skipped when DROP=0.
  - LEN: 2 cycles. Cycle 1 drives ct_addr=0. Cycle 2 captures L=ct_rddata and writes pt[0]=L (pt_wren=1, pt_addr=0).
  - MSG: 3 cycles per byte k=1..L.
    - c1: i=i+1, drive ct_addr=k.
    - c2: j=j+S[i], swap.
    - c3: pad=S[(S[i]+S[j]) mod 256]; write pt[k]=pad^ct_rddata; update pt_valid.
  - DONE: 1 cycle, then IDLE with rdy=1.
- The PRGA i/j state continues from DROP into MSG; it is not reset between them.
- Latency from the accept edge to rdy=1 is exactly 515 + DROP + 3*L cycles.
- All index arithmetic is 8-bit, wrapping mod 256.
- The swap with i==j must leave S unchanged.
- L=0: only pt[0]=0 is written; pt_valid stays 1.
- L=255: last write to pt_addr=255; no address wrap.
- pt_valid is cleared on the first byte outside 0x20..0x7E and stays 0 for the rest of the run. The length byte is not checked.
- At most one pt_wren pulse per cycle; pt_wren=0 in IDLE, INIT, KSA, DROP and DONE.

Test Plan:
- KEY_BYTES=3, key=0x4B6579 ("Key"), ct = 09 BB F3 16 E8 D9 40 AF 0A D3 → pt = 09 then "Plaintext" (50 6C 61 69 6E 74 65 78 74), pt_valid=1, rdy high 515+27 cycles after accept.
- KEY_BYTES=4, key=0x57696B69 ("Wiki"), ct = 05 10 21 BF 04 20 → pt = 05 "pedia", pt_valid=1.
- DROP=1, KEY_BYTES=3, key "Key", ct = 08 F3 16 E8 D9 40 AF 0A D3 → pt = 08 "laintext"; latency 515+1+24.
- "Key" vector with ct[1]=0xEC → pt[1]=0x07, pt_valid=0, remaining bytes still "laintext". Then rerun with the original ct → pt_valid returns to 1.
- ct[0]=00 → exactly one pt_wren pulse (addr 0, data 00), rdy after 515 cycles. Also en pulsed mid-run is ignored, with no extra writes.
- rst=1 asserted during MSG byte 4 → rdy=1 and pt_wren=0 the next cycle. A fresh en then reproduces the first scenario exactly.
